// File: rtl/iw_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : iw_fetch_queue
// Description : In-order instruction-wait queue between the IF request stage
//               and ID. Each accepted fetch (or IF-side fetch exception) is
//               recorded as a token. In-order data_ok returns complete the
//               oldest pending token. Completed tokens leave through a
//               valid/ready handshake. A redirect (flush) drops all tokens
//               and turns every in-flight bus request into a discard credit,
//               so that stale returns are swallowed.
//
// Ports       : clk, resetn (async, active-low)
//               in_valid/in_ready, in_pc, in_has_exception, in_ecode,
//               in_esubcode            - token from IF
//               data_ok, rdata         - in-order instruction bus return
//               flush                  - pipeline redirect
//               out_valid/out_ready, out_pc, out_inst, out_has_exception,
//               out_ecode, out_esubcode - head token towards ID
//               discard_cnt            - stale returns still expected
//               pending_cnt            - tokens waiting for data_ok
//
// Options     : IW_HEAD_BYPASS_EN - when defined, a data_ok aimed at the head
//               token presents rdata to ID in the same cycle.
//
// Revision    : 1.0 - initial release
// ============================================================================
module iw_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     in_has_exception,
    input  logic [5:0]               in_ecode,
    input  logic [8:0]               in_esubcode,

    input  logic                     data_ok,
    input  logic [INST_W-1:0]        rdata,

    input  logic                     flush,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic                     out_has_exception,
    output logic [5:0]               out_ecode,
    output logic [8:0]               out_esubcode,

    output logic [$clog2(DEPTH):0]   discard_cnt,
    output logic [$clog2(DEPTH):0]   pending_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    // ------------------------------------------------------------------
    // Token storage
    // ------------------------------------------------------------------
    logic                r_valid [DEPTH];
    logic                r_done  [DEPTH];
    logic [PC_W-1:0]     r_pc    [DEPTH];
    logic [INST_W-1:0]   r_inst  [DEPTH];
    logic                r_exc   [DEPTH];
    logic [5:0]          r_ecode [DEPTH];
    logic [8:0]          r_esub  [DEPTH];

    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  r_discard;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]  w_pending;
    logic                w_tgt_found;
    logic [c_PTR_W-1:0]  w_tgt;
    logic [c_CNT_W:0]    w_occupancy;
    logic                w_in_ready;
    logic                w_push;
    logic                w_discard_hit;
    logic                w_fill;
    logic                w_fill_wr;
    logic                w_head_done;
    logic                w_bypass;
    logic                w_out_valid;
    logic                w_pop;
    logic [c_CNT_W-1:0]  w_discard_next;

    // Pending count and return target. The scan starts at head so the
    // first valid-but-not-done slot found is the oldest outstanding fetch;
    // exception tokens are born done and are therefore never targeted.
    always_comb begin : p_scan
        logic [c_PTR_W-1:0] v_idx;
        w_pending   = '0;
        w_tgt_found = 1'b0;
        w_tgt       = '0;
        v_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && !r_done[i]) begin
                w_pending = w_pending + c_CNT_W'(1);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + c_PTR_W'(i);
            if (!w_tgt_found && r_valid[v_idx] && !r_done[v_idx]) begin
                w_tgt_found = 1'b1;
                w_tgt       = v_idx;
            end
        end
    end

    // Tokens held plus stale requests still on the bus never exceed DEPTH,
    // which bounds outstanding bus requests to DEPTH.
    assign w_occupancy   = {1'b0, r_count} + {1'b0, r_discard};
    assign w_in_ready    = resetn && !flush && (w_occupancy < (c_CNT_W + 1)'(DEPTH));
    assign w_push        = in_valid && w_in_ready;

    assign w_discard_hit = data_ok && (r_discard != '0);
    // A return with nothing pending and nothing to discard is dropped.
    assign w_fill        = data_ok && (r_discard == '0) && w_tgt_found;

    assign w_head_done   = r_valid[r_head] && r_done[r_head];

`ifdef IW_HEAD_BYPASS_EN
    // The scan starts at head, so a target equal to head means the head
    // slot is valid and still waiting for this very word.
    assign w_bypass      = w_fill && (w_tgt == r_head);
`else
    assign w_bypass      = 1'b0;
`endif

    assign w_out_valid   = !flush && (w_head_done || w_bypass);
    assign w_pop         = w_out_valid && out_ready;
    // A bypassed head that pops this cycle is freed without being written.
    assign w_fill_wr     = w_fill && !(w_bypass && w_pop);

    // On flush every token still waiting for its word becomes a discard
    // credit; a return in the same cycle first consumes a credit or
    // completes a pending token, whichever it would have done anyway.
    always_comb begin
        w_discard_next = r_discard;
        if (flush) begin
            w_discard_next = r_discard - c_CNT_W'(w_discard_hit)
                           + w_pending - c_CNT_W'(w_fill);
        end else if (w_discard_hit) begin
            w_discard_next = r_discard - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_done[i]  <= 1'b0;
                r_pc[i]    <= '0;
                r_inst[i]  <= '0;
                r_exc[i]   <= 1'b0;
                r_ecode[i] <= '0;
                r_esub[i]  <= '0;
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_discard <= '0;
        end else begin
            r_discard <= w_discard_next;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_valid[i] <= 1'b0;
                    r_done[i]  <= 1'b0;
                end
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                // Fill, pop and push touch distinct slots: the push slot is
                // free, the fill slot is not done, the pop slot is done
                // (bypass case is excluded from the fill write above).
                if (w_fill_wr) begin
                    r_inst[w_tgt] <= rdata;
                    r_done[w_tgt] <= 1'b1;
                end
                if (w_pop) begin
                    r_valid[r_head] <= 1'b0;
                    r_done[r_head]  <= 1'b0;
                    r_head          <= r_head + c_PTR_W'(1);
                end
                if (w_push) begin
                    r_valid[r_tail] <= 1'b1;
                    r_done[r_tail]  <= in_has_exception;
                    r_pc[r_tail]    <= in_pc;
                    r_inst[r_tail]  <= '0;
                    r_exc[r_tail]   <= in_has_exception;
                    r_ecode[r_tail] <= in_ecode;
                    r_esub[r_tail]  <= in_esubcode;
                    r_tail          <= r_tail + c_PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (fields forced to zero whenever nothing is presented)
    // ------------------------------------------------------------------
    assign in_ready          = w_in_ready;
    assign out_valid         = w_out_valid;
    assign out_pc            = w_out_valid ? r_pc[r_head] : '0;
    assign out_inst          = !w_out_valid ? '0 : (w_bypass ? rdata : r_inst[r_head]);
    assign out_has_exception = w_out_valid && r_exc[r_head];
    assign out_ecode         = w_out_valid ? r_ecode[r_head] : '0;
    assign out_esubcode      = w_out_valid ? r_esub[r_head]  : '0;
    assign discard_cnt       = r_discard;
    assign pending_cnt       = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_iw_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_iw_fetch_queue
// Description : Self-checking bench for iw_fetch_queue. A transaction-level
//               model (a queue of in-flight tokens plus a discard credit
//               count) predicts per-cycle status and the sequence of tokens
//               handed to ID; a monitor compares the DUT against both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iw_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_pc = '0;
    logic          in_has_exception = 1'b0;
    logic [5:0]    in_ecode = '0;
    logic [8:0]    in_esubcode = '0;
    logic          data_ok = 1'b0;
    logic [31:0]   rdata = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_has_exception;
    logic [5:0]    out_ecode;
    logic [8:0]    out_esubcode;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] pending_cnt;

    always #5 clk = ~clk;

    iw_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pc             (in_pc),
        .in_has_exception  (in_has_exception),
        .in_ecode          (in_ecode),
        .in_esubcode       (in_esubcode),
        .data_ok           (data_ok),
        .rdata             (rdata),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_has_exception (out_has_exception),
        .out_ecode         (out_ecode),
        .out_esubcode      (out_esubcode),
        .discard_cnt       (discard_cnt),
        .pending_cnt       (pending_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          exc;
        logic [5:0]  ec;
        logic [8:0]  esc;
        bit          done;
    } tok_t;

    typedef struct {
        bit rdy;
        bit ov;
        int disc;
        int pend;
    } st_t;

    tok_t mq[$];     // tokens held, oldest first
    int   m_disc = 0;
    st_t  sq[$];     // expected per-cycle status
    tok_t pq[$];     // expected tokens delivered to ID, in order

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int model_pending();
        int n = 0;
        foreach (mq[i]) if (!mq[i].done) n++;
        return n;
    endfunction

    // One clock of stimulus: drive inputs at the falling edge, record what
    // the DUT must show this cycle, then advance the model past the next
    // rising edge.
    task automatic cycle(input bit rstn, input bit iv, input logic [31:0] pc,
                         input bit exc, input logic [5:0] ec, input logic [8:0] esc,
                         input bit dok, input logic [31:0] rd,
                         input bit fl, input bit ordy);
        st_t  s;
        tok_t t;
        bit   er, eo;
        @(negedge clk);
        resetn           = rstn;
        in_valid         = iv;
        in_pc            = pc;
        in_has_exception = exc;
        in_ecode         = ec;
        in_esubcode      = esc;
        data_ok          = dok;
        rdata            = rd;
        flush            = fl;
        out_ready        = ordy;
        if (!rstn) begin
            mq.delete();
            m_disc = 0;
        end
        er = rstn && !fl && (mq.size() + m_disc < DEPTH);
        eo = rstn && !fl && (mq.size() > 0) && mq[0].done;
        s.rdy  = er;
        s.ov   = eo;
        s.disc = m_disc;
        s.pend = model_pending();
        sq.push_back(s);
        if (!rstn) return;
        if (eo && ordy) begin
            pq.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (dok) begin
            if (m_disc > 0) m_disc--;
            else begin
                for (int i = 0; i < mq.size(); i++) begin
                    if (!mq[i].done) begin
                        t = mq[i];
                        t.inst = rd;
                        t.done = 1'b1;
                        mq[i] = t;
                        break;
                    end
                end
            end
        end
        if (iv && er) begin
            t.pc   = pc;
            t.inst = '0;
            t.exc  = exc;
            t.ec   = ec;
            t.esc  = esc;
            t.done = exc;
            mq.push_back(t);
        end
        if (fl) begin
            m_disc += model_pending();
            mq.delete();
        end
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, ordy);
    endtask

    task automatic push(input logic [31:0] pc, input bit ordy);
        cycle(1'b1, 1'b1, pc, 1'b0, '0, '0, 1'b0, '0, 1'b0, ordy);
    endtask

    task automatic ret(input logic [31:0] rd, input bit ordy);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1, rd, 1'b0, ordy);
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sq.size() > 0) begin
                st_t s;
                s = sq.pop_front();
                check("in_ready",    64'(in_ready),    64'(s.rdy));
                check("out_valid",   64'(out_valid),   64'(s.ov));
                check("discard_cnt", 64'(discard_cnt), 64'(s.disc));
                check("pending_cnt", 64'(pending_cnt), 64'(s.pend));
                if (!s.ov)
                    check("idle_fields_zero",
                          64'({out_pc, out_inst, out_has_exception, out_ecode, out_esubcode} != '0), 64'(0));
            end
            if (out_valid && out_ready) begin
                if (pq.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_pop: actual pc=%0h required no pop (t=%0t)", out_pc, $time);
                end else begin
                    tok_t e;
                    e = pq.pop_front();
                    check("pop_pc",   64'(out_pc),            64'(e.pc));
                    check("pop_inst", 64'(out_inst),          64'(e.inst));
                    check("pop_exc",  64'(out_has_exception), 64'(e.exc));
                    check("pop_ecode", 64'(out_ecode),        64'(e.ec));
                    check("pop_esub", 64'(out_esubcode),      64'(e.esc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset
        cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        check("reset_in_ready", 64'(in_ready), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        idle(1'b0);
        #2;
        check("post_reset_in_ready", 64'(in_ready), 64'(1));

        // Reset mid-traffic
        push(32'h1c00_0000, 1'b0);
        push(32'h1c00_0004, 1'b0);
        push(32'h1c00_0008, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        check("midreset_discard", 64'(discard_cnt), 64'(0));
        check("midreset_pending", 64'(pending_cnt), 64'(0));
        push(32'h1c00_0000, 1'b0);
        ret(32'h0280_0000, 1'b0);
        idle(1'b0);
        #2;
        check("after_reset_valid", 64'(out_valid), 64'(1));
        check("after_reset_pc",    64'(out_pc),    64'(32'h1c00_0000));
        check("after_reset_inst",  64'(out_inst),  64'(32'h0280_0000));
        idle(1'b1);

        // Fill and drain
        for (int i = 0; i < 4; i++) push(32'h1c00_0000 + 32'(4 * i), 1'b0);
        for (int i = 0; i < 4; i++) ret(32'hA0 + 32'(i), 1'b0);
        idle(1'b0);
        #2;
        check("full_in_ready", 64'(in_ready),    64'(0));
        check("full_pending",  64'(pending_cnt), 64'(0));
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Flush with three pending
        for (int i = 0; i < 3; i++) push(32'h1c00_0040 + 32'(4 * i), 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        #2;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        idle(1'b0);
        #2;
        check("flush_discard", 64'(discard_cnt), 64'(3));
        for (int i = 0; i < 3; i++) ret(32'hDEAD_0000 + 32'(i), 1'b0);
        push(32'h1c00_0100, 1'b0);
        ret(32'h0000_BEEF, 1'b0);
        idle(1'b0);
        #2;
        check("post_discard_inst", 64'(out_inst), 64'(32'h0000_BEEF));
        idle(1'b1);

        // Flush coinciding with a discarded return: discard 1, pending 2
        push(32'h1c00_0200, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        push(32'h1c00_0204, 1'b1);
        push(32'h1c00_0208, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h1234, 1'b1, 1'b1);
        idle(1'b1);
        #2;
        check("flush_dok_discard", 64'(discard_cnt), 64'(2));
        ret(32'h1, 1'b1);
        ret(32'h2, 1'b1);

        // Exception token behind two pending fetches
        push(32'h1c00_0300, 1'b1);
        push(32'h1c00_0304, 1'b1);
        cycle(1'b1, 1'b1, 32'h1c00_0308, 1'b1, 6'h08, 9'h000, 1'b0, '0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        ret(32'h11, 1'b1);
        ret(32'h22, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            bit          rstn, iv, exc, dok, fl, ordy;
            logic [5:0]  ec;
            logic [8:0]  esc;
            rstn = ($urandom_range(0, 499) != 0);
            iv   = ($urandom_range(0, 9) < 6);
            exc  = ($urandom_range(0, 9) == 0);
            ec   = exc ? 6'($urandom) : 6'h0;
            esc  = exc ? 9'($urandom) : 9'h0;
            dok  = ((m_disc + model_pending()) > 0) && ($urandom_range(0, 1) == 1);
            fl   = ($urandom_range(0, 29) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            cycle(rstn, iv, $urandom, exc, ec, esc, dok, $urandom, fl, ordy);
        end
        idle(1'b0);

        @(negedge clk);
        #3;
        check("status_queue_drained", 64'(sq.size()), 64'(0));
        check("pop_queue_drained",    64'(pq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iw_fetch_queue.md
# iw_fetch_queue

Parametrised instruction-wait queue between the IF request stage and ID. Records each fetch accepted by the instruction SRAM-like bus (or each IF-detected fetch exception) as an in-order token, matches in-order `data_ok` returns to the oldest pending token, and presents completed tokens to ID through a valid/ready handshake. It supports up to `DEPTH` outstanding fetches. On a pipeline redirect it drops every token and converts each in-flight memory request into a discard credit, so stale returns are swallowed.

## Interface
- `DEPTH`, 4: token slots and maximum outstanding memory requests; power of two, 2..8.
- `PC_W`, 32: PC width.
- `INST_W`, 32: instruction width.
- `clk` input 1: clock.
- `resetn` input 1: asynchronous, active-low reset.
- `in_valid` input 1: IF presents a token this cycle.
- `in_ready` output 1: queue can accept a token.
- `in_pc` input PC_W: fetch PC.
- `in_has_exception` input 1: IF-side fetch exception; no memory request was issued for this token.
- `in_ecode` input 6 / `in_esubcode` input 9: exception codes.
- `data_ok` input 1: instruction bus returns one word.
- `rdata` input INST_W: returned word.
- `flush` input 1: OR of exception, ertn, branch, TLB-refetch and CSR redirects.
- `out_valid` output 1: head token complete.
- `out_ready` input 1: ID accepts head.
- `out_pc` output PC_W, `out_inst` output INST_W, `out_has_exception` output 1, `out_ecode` output 6, `out_esubcode` output 9: head token fields.
- `discard_cnt` output $clog2(DEPTH)+1: outstanding stale returns.
- `pending_cnt` output $clog2(DEPTH)+1: tokens awaiting `data_ok`.

## Operation
- Storage:
  - Circular buffer of DEPTH slots. Each slot holds {valid, done, pc, inst, exc, ecode, esubcode}.
  - Head pointer, tail pointer and count register.
- Push:
  - Occurs on `in_valid && in_ready`. Writes the slot at tail and advances tail.
  - `done` = `in_has_exception`. An exception token has `inst` = 0 and counts as no memory request.
- `in_ready` = `resetn && !flush && (count + discard_cnt) < DEPTH`. This bounds bus requests in flight to DEPTH, so `discard_cnt` ≤ DEPTH.
- Return, on `data_ok`:
  - If `discard_cnt` != 0: decrement `discard_cnt` and drop the word.
  - Otherwise: write `rdata` into the oldest valid slot with `done` = 0, found by a priority scan from head, and set its `done`.
  - `data_ok` with `discard_cnt` = 0 and `pending_cnt` = 0 is a protocol error. The word is dropped and no state changes.
- Pop:
  - `out_valid` = head slot valid and done. Output fields come from the head slot.
  - All output fields read 0 when `out_valid` = 0.
  - `out_valid && out_ready` clears the head slot and advances head.
- Flush (highest priority):
  - All slots are invalidated and pointers reset to 0. `out_valid` is forced to 0 in the flush cycle.
  - Next `discard_cnt` = `discard_cnt` − (data_ok && discard_cnt≠0) + `pending_cnt` − (data_ok && discard_cnt=0 && pending_cnt≠0).
  - A same-cycle push cannot occur, because `in_ready` = 0 during flush.
- Simultaneous push and pop: count is unchanged. A same-cycle push and `data_ok` cannot target the slot being pushed.
- `pending_cnt` = number of valid slots with `done` = 0.

## Timing
- Reset (async assert, sync-safe deassert): every slot invalid; head, tail, count and `discard_cnt` = 0; all outputs 0; `in_ready` = 1 from the first cycle after deassert.
- Latency:
  - Push to `out_valid` for an exception token: 1 cycle.
  - `data_ok` to `out_valid` for the head token: 1 cycle (registered `done`), unless the bypass below is compiled in.
- `out_*` are stable while `out_valid && !out_ready && !flush`.
- Full (count = DEPTH): `in_ready` = 0. A pop in the same cycle does not re-enable it until the next cycle.
- Empty: `out_valid` = 0.
- Pointers wrap modulo DEPTH.

## Configuration
- `IW_HEAD_BYPASS_EN`:
  - When defined: if the head slot is valid, not done, and is the return target of a non-discarded `data_ok`, then `out_valid` = 1 combinationally with `out_inst` = `rdata`. If `out_ready` is also high, the head pops in that cycle without being written.
  - When undefined: `out_valid` depends only on registered state.

## Test plan
- Reset mid-traffic: DEPTH=4, push 3 tokens, assert `resetn`=0 for 1 cycle -> all outputs 0, `discard_cnt`=0; push at 0x1c000000 then `data_ok` rdata=0x02800000 -> `out_valid` 1 cycle later with those values.
- Fill and drain: push PCs 0x1c000000..0x1c00000c, `data_ok` ×4 (0xA0..0xA3) with `out_ready`=0 -> `in_ready`=0, `pending_cnt`=0; raise `out_ready` -> four pops in PC order, `inst` 0xA0..0xA3.
- Flush with 3 pending -> `discard_cnt`=3, `out_valid`=0; next 3 `data_ok` dropped; 4th `data_ok` fills a newly pushed token.
- Flush in the same cycle as `data_ok`, `discard_cnt`=1, pending=2 -> `discard_cnt` becomes 2.
- Exception token (ecode 0x08) pushed behind 2 pending tokens -> it is held until both return, leaves third, and `data_ok` never targets it.
- With `IW_HEAD_BYPASS_EN`: `data_ok` for head with `out_ready`=1 -> `out_valid` and `out_inst`=`rdata` in the same cycle, count decremented next cycle.
